// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port SRAM between the instruction-fetch port and the
// load/store port. The data port has fixed priority. A starvation counter
// forces a fetch grant after MAX_WAIT consecutive denied fetch cycles.
// Grants are combinational. Read data returns one cycle after the grant and
// is tagged with the port that owned the access.
module sram_port_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    // Instruction-fetch port.
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DW-1:0]     i_rdata,

    // Load/store port.
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DW/8-1:0]   d_be,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,

    // SRAM macro side.
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [DW/8-1:0]   sram_web,
    output logic [AW-1:0]     sram_a,
    output logic [DW-1:0]     sram_di,
    input  logic [DW-1:0]     sram_do
);

    localparam int         BW       = DW / 8;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    // Elaboration-time sanity checks on the parameter set.
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("sram_port_arbiter: MAX_WAIT must be in 1..15");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("sram_port_arbiter: DW must be a multiple of 8");
    end

    // Starvation counter: consecutive cycles the fetch port has been denied.
    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    // Return tags: which port owns the read data arriving next cycle.
    logic       rd_i_q;
    logic       rd_i_d;
    logic       rd_d_q;
    logic       rd_d_d;

    // Fetch has waited long enough to override data priority.
    logic       fetch_forced;
    // Granted access is a data-port write.
    logic       d_write;

    // Grant selection: data wins ties unless fetch has been starved MAX_WAIT cycles.
    always_comb begin
        i_gnt        = 1'b0;
        d_gnt        = 1'b0;
        fetch_forced = (wait_cnt_q >= WAIT_MAX);
        if (!rst) begin
            if (i_req && (!d_req || fetch_forced)) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    // Starvation counter next state: count denied fetch cycles, saturating.
    always_comb begin
        wait_cnt_d = '0;
        if (i_req && !i_gnt) begin
            if (wait_cnt_q >= WAIT_MAX) begin
                wait_cnt_d = WAIT_MAX;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
    end

    // Return tag next state: a read granted now returns data next cycle.
    always_comb begin
        d_write = d_gnt & d_we;
        rd_i_d  = i_gnt;
        rd_d_d  = d_gnt & ~d_we;
    end

    // SRAM drive: granted address and write controls, idle values otherwise.
    always_comb begin
        sram_cs  = 1'b0;
        sram_a   = '0;
        sram_di  = '0;
        sram_web = {BW{1'b1}};
        if (i_gnt) begin
            sram_cs = 1'b1;
            sram_a  = i_addr;
        end else if (d_gnt) begin
            sram_cs = 1'b1;
            sram_a  = d_addr;
            if (d_write) begin
                // A write with no byte enables still occupies the slot but
                // leaves every byte lane disabled.
                sram_web = ~d_be;
                sram_di  = d_wdata;
            end
        end
    end

    // State registers; reset clears pending returns so an in-flight read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rd_i_q     <= 1'b0;
            rd_d_q     <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_i_q     <= rd_i_d;
            rd_d_q     <= rd_d_d;
        end
    end

    // Response outputs: both ports see the raw SRAM data, qualified by their tag.
    always_comb begin
        i_rvalid = rd_i_q;
        d_rvalid = rd_d_q;
        sram_oe  = rd_i_q | rd_d_q;
        i_rdata  = sram_do;
        d_rdata  = sram_do;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed vector table, reset corner cases
// and randomized traffic compared against a transaction-level reference model.
module tb_sram_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          sram_cs;
    logic          sram_oe;
    logic [BW-1:0] sram_web;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_di;
    logic [DW-1:0] sram_do;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
    );

    // Behavioural single-port SRAM driven only by the DUT's SRAM pins.
    logic [DW-1:0] smem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            for (int b = 0; b < BW; b++)
                if (!sram_web[b]) smem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
            sram_do <= smem[sram_a];
        end
    end

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 'h10) return 32'hDEADBEEF;
        if (a == 'h20) return 32'hAAAAAAAA;
        return {16'hC0DE, 16'(a)} ^ (32'(a) << 20);
    endfunction

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] ref_mem [int];
    int            m_wait;     // consecutive denied fetch cycles
    bit            m_ig, m_dg; // grants the model expects this cycle
    bit            m_iv, m_dv; // responses the model expects this cycle
    logic [DW-1:0] m_rdata;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        m_wait = 0; m_iv = 0; m_dv = 0; m_ig = 0; m_dg = 0; m_rdata = '0;
    endtask

    task automatic model_eval();
        m_ig = i_req && (!d_req || m_wait >= MW);
        m_dg = d_req && !m_ig;
    endtask

    task automatic model_commit();
        logic [DW-1:0] w;
        m_rdata = m_ig ? ref_rd(int'(i_addr)) : ref_rd(int'(d_addr));
        m_iv = m_ig;
        m_dv = m_dg && !d_we;
        if (m_dg && d_we) begin
            w = ref_rd(int'(d_addr));
            for (int b = 0; b < BW; b++)
                if (d_be[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
            ref_mem[int'(d_addr)] = w;
        end
        if (i_req && !m_ig) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
        else m_wait = 0;
    endtask

    // ---------------- vectors and checking ----------------
    typedef struct {
        bit            ireq;
        logic [AW-1:0] iaddr;
        bit            dreq;
        bit            dwe;
        logic [BW-1:0] dbe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        bit            ig;
        bit            dg;
        logic [BW-1:0] web;
        logic [AW-1:0] a;
        bit            iv;
        bit            dv;
        logic [DW-1:0] rdata;
    } vec_t;

    function automatic vec_t mk(bit ireq, int iaddr, bit dreq, bit dwe, int dbe, int daddr,
                                logic [DW-1:0] dwd, bit ig, bit dg, int web, int a,
                                bit iv, bit dv, logic [DW-1:0] rdata);
        vec_t v;
        v.ireq = ireq; v.iaddr = AW'(iaddr); v.dreq = dreq; v.dwe = dwe;
        v.dbe = BW'(dbe); v.daddr = AW'(daddr); v.dwd = dwd;
        v.ig = ig; v.dg = dg; v.web = BW'(web); v.a = AW'(a);
        v.iv = iv; v.dv = dv; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " i_gnt"}, i_gnt, 0);
        chk({tag, " d_gnt"}, d_gnt, 0);
        chk({tag, " i_rvalid"}, i_rvalid, 0);
        chk({tag, " d_rvalid"}, d_rvalid, 0);
        chk({tag, " sram_cs"}, sram_cs, 0);
        chk({tag, " sram_oe"}, sram_oe, 0);
        chk({tag, " sram_web"}, sram_web, {BW{1'b1}});
        chk({tag, " sram_a"}, sram_a, 0);
        chk({tag, " sram_di"}, sram_di, 0);
    endtask

    task automatic apply(input vec_t v);
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.dwe; d_be = v.dbe; d_addr = v.daddr; d_wdata = v.dwd;
    endtask

    task automatic check_outputs(input vec_t e, input string tag);
        chk({tag, " i_gnt"}, i_gnt, e.ig);
        chk({tag, " d_gnt"}, d_gnt, e.dg);
        chk({tag, " sram_cs"}, sram_cs, e.ig | e.dg);
        chk({tag, " sram_web"}, sram_web, e.web);
        chk({tag, " sram_a"}, sram_a, e.a);
        if (e.dg && d_we) chk({tag, " sram_di"}, sram_di, d_wdata);
        else if (!e.ig && !e.dg) chk({tag, " sram_di idle"}, sram_di, 0);
        chk({tag, " i_rvalid"}, i_rvalid, e.iv);
        chk({tag, " d_rvalid"}, d_rvalid, e.dv);
        chk({tag, " sram_oe"}, sram_oe, e.iv | e.dv);
        if (e.iv) chk({tag, " i_rdata"}, i_rdata, e.rdata);
        if (e.dv) chk({tag, " d_rdata"}, d_rdata, e.rdata);
    endtask

    function automatic vec_t model_expect();
        vec_t e;
        e = mk(0, 0, 0, 0, 0, 0, '0, 0, 0, '1, 0, 0, 0, '0);
        e.ig = m_ig; e.dg = m_dg;
        e.web = (m_dg && d_we) ? ~d_be : {BW{1'b1}};
        e.a = m_ig ? i_addr : (m_dg ? d_addr : '0);
        e.iv = m_iv; e.dv = m_dv; e.rdata = m_rdata;
        return e;
    endfunction

    // One clock cycle: inputs are already applied; check at the falling edge.
    task automatic run_cycle(input bit use_tbl, input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        model_eval();
        e = use_tbl ? v : model_expect();
        check_outputs(e, tag);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t none;

    initial begin
        logic [DW-1:0] v30, v40;
        for (int a = 0; a < (1 << AW); a++) smem[a] = init_val(a);
        none = mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 0, 0, '0);
        v30 = init_val('h30);
        v40 = init_val('h40);

        // Single fetch.
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 0, '0, 1, 0, 'hF, 'h10, 0, 0, '0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 1, 0, 32'hDEADBEEF));
        // Partial write then read-back.
        tbl.push_back(mk(0, 0, 1, 1, 'h3, 'h20, 32'h12345678, 0, 1, 'hC, 'h20, 0, 0, '0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 'h20, '0, 0, 1, 'hF, 'h20, 0, 0, '0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 0, 1, 32'hAAAA5678));
        // Write with no byte enables leaves memory unchanged.
        tbl.push_back(mk(0, 0, 1, 1, 'h0, 'h20, 32'hFFFFFFFF, 0, 1, 'hF, 'h20, 0, 0, '0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 'h20, '0, 0, 1, 'hF, 'h20, 0, 0, '0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 0, 1, 32'hAAAA5678));
        // Contention: data wins 4 cycles, fetch forced in the 5th, data resumes.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 'h30, 1, 0, 0, 'h40, '0, 0, 1, 'hF, 'h40, 0, k > 0, v40));
        tbl.push_back(mk(1, 'h30, 1, 0, 0, 'h40, '0, 1, 0, 'hF, 'h30, 0, 1, v40));
        tbl.push_back(mk(1, 'h30, 1, 0, 0, 'h40, '0, 0, 1, 'hF, 'h40, 1, 0, v30));
        tbl.push_back(mk(1, 'h30, 0, 0, 0, 0, '0, 1, 0, 'hF, 'h30, 0, 1, v40));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 1, 0, v30));
        // Streaming: alternate fetch and data reads with no bubbles.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                tbl.push_back(mk(1, 'h10, 0, 0, 0, 0, '0, 1, 0, 'hF, 'h10,
                                 0, k > 0, 32'hAAAA5678));
            else
                tbl.push_back(mk(0, 0, 1, 0, 0, 'h20, '0, 0, 1, 'hF, 'h20,
                                 1, 0, 32'hDEADBEEF));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, '0, 0, 0, 'hF, 0, 0, 1, 32'hAAAA5678));

        // Reset state: requests asserted but no grant while rst is high.
        rst = 1'b1;
        apply(mk(1, 'h5, 1, 1, 'hF, 'h6, 32'h1, 0, 0, 0, 0, 0, 0, '0));
        #2;
        chk_idle("reset");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        apply(none);
        rst = 1'b0;

        foreach (tbl[k]) begin
            apply(tbl[k]);
            run_cycle(1'b1, tbl[k], $sformatf("tbl%0d", k));
        end

        // Reset while a data read is in flight: its response is dropped.
        apply(mk(0, 0, 1, 0, 0, 'h20, '0, 0, 0, 0, 0, 0, 0, '0));
        run_cycle(1'b0, none, "rst_mid_gnt");
        rst = 1'b1;
        #1;
        chk_idle("rst_mid");
        model_reset();
        @(posedge clk); #1;
        chk_idle("rst_hold");
        rst = 1'b0;
        run_cycle(1'b0, none, "rst_release");
        apply(none);
        run_cycle(1'b0, none, "rst_after");

        // Randomized traffic honouring the hold-until-grant protocol.
        for (int n = 0; n < 3000; n++) begin
            if (!i_req || m_ig) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = AW'($urandom_range(0, 31));
            end
            if (!d_req || m_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = BW'($urandom);
                d_addr  = AW'($urandom_range(0, 31));
                d_wdata = $urandom;
            end
            run_cycle(1'b0, none, "rnd");
        end
        apply(none);
        run_cycle(1'b0, none, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port SRAM_wrapper macro between the CPU instruction-fetch port and its load/store port. Used in memory-reduced builds where IM and DM occupy one array. Both ports use a request/grant handshake. The data port has fixed priority, bounded by a starvation counter that guarantees fetch progress. Read data returns one cycle after grant, tagged to the owning port. Throughput is one access per cycle.

## Interface
Parameters:
- AW, 14: SRAM word-address width.
- DW, 32: data width. Byte enables are DW/8 wide.
- MAX_WAIT, 4: consecutive denied fetch cycles before fetch is forced to win. Legal range 1..15.

Ports:
- clk  in  1  single clock. All registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request. Held with i_addr stable until i_gnt.
- i_addr  in  AW  fetch word address.
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid (registered).
- i_rdata  out  DW  fetch data. Equals sram_do.
- d_req  in  1  data request. Held with d_we, d_be, d_addr, d_wdata stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DW/8  byte enables for writes, active-high.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data access granted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (registered). Never asserted for writes.
- d_rdata  out  DW  load data. Equals sram_do.
- sram_cs  out  1  SRAM chip select.
- sram_oe  out  1  SRAM output enable.
- sram_web  out  DW/8  per-byte write enable, active-low.
- sram_a  out  AW  SRAM address.
- sram_di  out  DW  SRAM write data.
- sram_do  in  DW  SRAM read data. Valid in the cycle after the address is sampled.

## Operation
Grant selection, evaluated combinationally each cycle. All grants are 0 while rst=1.
- Only one request: that port wins.
- Both requests, wait_cnt < MAX_WAIT: data wins.
- Both requests, wait_cnt == MAX_WAIT: fetch wins.
- At most one of i_gnt/d_gnt is high in any cycle.

wait_cnt register (4 bits):
- Increments when i_req=1 and i_gnt=0. Saturates at MAX_WAIT.
- Clears when i_gnt=1 or i_req=0.

SRAM drive in the grant cycle:
- sram_cs=1 and sram_a = the granted address.
- Data write: sram_web = ~d_be, sram_di = d_wdata.
- Any read: sram_web = all ones.
- A write with d_be=0 is still granted: cs=1, web all ones, no array change.

SRAM drive when idle: sram_cs=0, sram_a=0, sram_di=0, sram_web all ones.

Return tracking (registered):
- rd_i <= i_gnt.
- rd_d <= d_gnt & ~d_we.
- i_rvalid = rd_i, d_rvalid = rd_d.
- sram_oe = rd_i | rd_d.

A requester may drop or change its request only after its grant. Changing it earlier is a protocol violation and behaviour is undefined.

## Timing
- Grant has 0-cycle latency from req, with no register in the req→gnt path.
- Read latency is 1 cycle: grant in cycle N, rvalid and rdata in cycle N+1.
- Writes complete in the grant cycle with no response. A read of the same address granted in cycle N+1 returns the new data.
- Back-to-back grants every cycle are allowed on either port or alternating. A return in N+1 overlaps the next access's grant in N+1 with no bubble.
- Worst-case fetch wait under continuous data requests is MAX_WAIT cycles. The grant comes in cycle MAX_WAIT after i_req rises, with wait_cnt counting 0..MAX_WAIT.
- After a forced fetch grant, wait_cnt=0 and data priority resumes the next cycle.

Reset (asynchronous, takes effect immediately):
- wait_cnt=0, rd_i=0, rd_d=0.
- Outputs: i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, sram_cs=0, sram_oe=0, sram_web all ones, sram_a=0, sram_di=0.
- A read granted before reset asserts returns no rvalid. Requesters must re-issue it.
- First grant possible in the first cycle with rst=0.

## Test plan
- Single fetch: i_req=1 with addr 0x0010 in cycle 0 → i_gnt=1, sram_cs=1, sram_a=0x0010 in cycle 0. i_rvalid=1, sram_oe=1 and i_rdata = preloaded 0xDEADBEEF in cycle 1. d_rvalid stays 0.
- Write then read: d write addr 0x0020, be=4'b0011, wdata=0x12345678 over a preloaded 0xAAAAAAAA → sram_web=4'b1100. A d read of 0x0020 next cycle returns 0xAAAA5678 with d_rvalid=1 and no write response.
- Contention, MAX_WAIT=4: i_req and d_req held high continuously from cycle 0 → d_gnt in cycles 0-3, i_gnt in cycle 4, d_gnt in cycle 5. Never both grants high in one cycle.
- Streaming: alternating i and d reads for 8 cycles → one grant per cycle. Each rvalid lands on the correct port one cycle later with no drops.
- Reset mid-read: grant a d read in cycle N and assert rst in cycle N+1 → d_rvalid=0, sram_oe=0 and all SRAM outputs at idle values immediately. After release, the first request is granted in the same cycle.
- Partial write mask: d_be=4'b0000 write → sram_cs=1 and web=4'b1111. A subsequent read shows memory unchanged.
